// File: rtl/clock_set_controller.sv
// Button front end for the time-field counters: sync/debounce, RUN/SET field select, up/down pulses with auto-repeat.
// Press-to-first-pulse is DB_CYCLES+3 cycles from the raw edge; there is no backpressure and pulses are single-cycle.
module clock_set_controller #(
  parameter int DB_CYCLES     = 8,
  parameter int REPEAT_DELAY  = 32,
  parameter int REPEAT_PERIOD = 8,
  parameter int IDLE_TIMEOUT  = 1024,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_mode,
  input  logic btn_up,
  input  logic btn_down,
  output logic mode_second,
  output logic mode_minute,
  output logic mode_hour,
  output logic up,
  output logic down,
  output logic setting
);

  typedef enum logic [1:0] {RUN = 2'd0, SET_SEC = 2'd1, SET_MIN = 2'd2, SET_HOUR = 2'd3} state_t;

  state_t                  state, nxt;
  logic [2:0]              raw, sync1, sync2, stb, stb_d;
  logic [2:0][CNT_W-1:0]   db_cnt;
  logic [CNT_W-1:0]        idle_cnt, rep_cnt;
  logic                    armed;
  logic [2:0]              press, rel;
  logic                    activity, mode_press, timeout, state_chg;
  logic                    excl_up, excl_dn, start_hold, pulse_ok;

  // Bit 0 = mode, bit 1 = up, bit 2 = down throughout.
  assign raw = {btn_down, btn_up, btn_mode};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stb    <= '0;
      stb_d  <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      stb_d <= stb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
          stb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press      = stb & ~stb_d;
  assign rel        = ~stb & stb_d;
  assign activity   = |(press | rel);
  assign mode_press = press[0];
  assign excl_up    = stb[1] & ~stb[2];
  assign excl_dn    = stb[2] & ~stb[1];
  // A hold starts on a press or when the other button lets go while this one stays down.
  assign start_hold = (excl_up & ~(stb_d[1] & ~stb_d[2])) |
                      (excl_dn & ~(stb_d[2] & ~stb_d[1]));
  assign timeout    = (state != RUN) && (idle_cnt == CNT_W'(IDLE_TIMEOUT - 1)) && !activity;
  assign state_chg  = mode_press | timeout;
  assign pulse_ok   = (state != RUN) && armed && !state_chg && (excl_up | excl_dn);

  always_comb begin
    nxt = state;
    if (mode_press) begin
      case (state)
        RUN:     nxt = SET_SEC;
        SET_SEC: nxt = SET_MIN;
        SET_MIN: nxt = SET_HOUR;
        default: nxt = RUN;
      endcase
    end else if (timeout) begin
      nxt = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      mode_second <= 1'b1;
      mode_minute <= 1'b1;
      mode_hour   <= 1'b1;
      setting     <= 1'b0;
      up          <= 1'b0;
      down        <= 1'b0;
      idle_cnt    <= '0;
      rep_cnt     <= '0;
      armed       <= 1'b0;
    end else begin
      state       <= nxt;
      mode_second <= (nxt != SET_SEC);
      mode_minute <= (nxt != SET_MIN);
      mode_hour   <= (nxt != SET_HOUR);
      setting     <= (nxt != RUN);

      if (nxt == RUN || state_chg || activity) idle_cnt <= '0;
      else if (idle_cnt != '1)                  idle_cnt <= idle_cnt + 1'b1;

      // A button held across a field change must be released before it can adjust the new field.
      if (state_chg)              armed <= 1'b0;
      else if (!stb[1] && !stb[2]) armed <= 1'b1;

      up   <= 1'b0;
      down <= 1'b0;
      if (!pulse_ok) begin
        rep_cnt <= '0;
      end else if (start_hold) begin
        rep_cnt <= '0;
        up      <= excl_up;
        down    <= excl_dn;
      end else if (rep_cnt == CNT_W'(REPEAT_DELAY - 1)) begin
        rep_cnt <= CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
        up      <= excl_up;
        down    <= excl_dn;
      end else if (rep_cnt != '1) begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: directed scenarios plus random button traffic against a cycle reference model.
module tb_clock_set_controller;
  localparam int DB = 8, RD = 32, RP = 8, TO = 1024;

  logic clk = 1'b0, rst_n = 1'b0;
  logic btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic mode_second, mode_minute, mode_hour, up, down, setting;

  clock_set_controller dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .mode_second(mode_second), .mode_minute(mode_minute), .mode_hour(mode_hour),
    .up(up), .down(down), .setting(setting)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int n = 0;
  int up_q[$];
  int pulse_cnt = 0;

  // Reference model state
  bit [2:0] m_s1, m_s2, m_stb, m_stbd;
  int       m_run[3];
  int       m_state, m_evt, m_prev_dir, m_age;
  bit       m_armed;
  bit       e_up, e_dn, e_set;
  bit [2:0] e_mode;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stb = '0; m_stbd = '0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_state = 0; m_evt = n; m_prev_dir = 0; m_age = -1; m_armed = 0;
    e_up = 0; e_dn = 0; e_set = 0; e_mode = 3'b111;
  endtask

  task automatic model_step();
    bit [2:0] stb_o, prs, rls;
    bit act, tout, chg, allowed, fire;
    int dir, new_state, idle_old;
    n++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    stb_o = m_stb;
    prs   = stb_o & ~m_stbd;
    rls   = ~stb_o & m_stbd;
    act   = |(prs | rls);
    dir   = (stb_o[1] && !stb_o[2]) ? 1 : (stb_o[2] && !stb_o[1]) ? 2 : 0;
    idle_old = (n - 1) - m_evt;
    tout  = (m_state != 0) && (idle_old == TO - 1) && !act;
    chg   = prs[0] || tout;
    new_state = prs[0] ? (m_state + 1) % 4 : (tout ? 0 : m_state);
    allowed = (m_state != 0) && m_armed && !chg;
    fire = 0;
    if (allowed && dir != 0) begin
      if (dir != m_prev_dir || m_age < 0) m_age = 0;
      else m_age++;
      fire = (m_age == 0) || (m_age >= RD && (m_age - RD) % RP == 0);
    end else begin
      m_age = -1;
    end
    e_up = fire && dir == 1;
    e_dn = fire && dir == 2;
    m_prev_dir = dir;
    if (chg) m_armed = 0;
    else if (!stb_o[1] && !stb_o[2]) m_armed = 1;
    if (new_state == 0 || chg || act) m_evt = n;
    m_state = new_state;
    e_mode = {new_state != 3, new_state != 2, new_state != 1};
    e_set  = (new_state != 0);
    for (int i = 0; i < 3; i++) begin
      if (m_s2[i] != m_stb[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_stb[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_stbd = stb_o;
    m_s2 = m_s1;
    m_s1 = {btn_down, btn_up, btn_mode};
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("up", up, e_up);
    chk("down", down, e_dn);
    chk("mode", {mode_hour, mode_minute, mode_second}, e_mode);
    chk("setting", setting, e_set);
    if (up === 1'b1) up_q.push_back(n);
    if (up === 1'b1 || down === 1'b1) pulse_cnt++;
  endtask

  task automatic run(int k);
    repeat (k) cycle();
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    run(20);
    btn_mode = 1'b0;
    run(20);
  endtask

  initial begin
    int k0, t0;
    int unsigned v;
    model_reset();
    run(3);
    rst_n = 1'b1;

    // Reset state after 100 idle cycles
    run(100);
    chk("reset_mode", {mode_hour, mode_minute, mode_second}, 8'h7);
    chk("reset_updown", {up, down}, 8'h0);
    chk("reset_setting", setting, 8'h0);

    // Field select sequence
    press_mode();
    chk("sel_sec", {mode_hour, mode_minute, mode_second}, 8'h6);
    press_mode();
    chk("sel_min", {mode_hour, mode_minute, mode_second}, 8'h5);

    // Asynchronous reset in SET_MIN, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mode", {mode_hour, mode_minute, mode_second}, 8'h7);
    chk("arst_outs", {up, down, setting}, 8'h0);
    model_reset();
    run(3);
    rst_n = 1'b1;
    run(5);

    press_mode();
    chk("seq_sec", {mode_hour, mode_minute, mode_second}, 8'h6);
    press_mode();
    chk("seq_min", {mode_hour, mode_minute, mode_second}, 8'h5);
    press_mode();
    chk("seq_hour", {mode_hour, mode_minute, mode_second}, 8'h3);
    press_mode();
    chk("seq_run", {mode_hour, mode_minute, mode_second}, 8'h7);

    // Glitch rejection then held up with auto-repeat, in SET_SEC
    press_mode();
    pulse_cnt = 0;
    btn_up = 1'b1;
    run(5);
    btn_up = 1'b0;
    run(20);
    chk("glitch_pulses", pulse_cnt[7:0], 8'h0);
    up_q.delete();
    k0 = n;
    btn_up = 1'b1;
    run(100);
    btn_up = 1'b0;
    run(30);
    chk("rep_count_min", (up_q.size() >= 3) ? 8'h1 : 8'h0, 8'h1);
    chk("rep_first", (up_q.size() > 0) ? 8'(up_q[0] - k0) : 8'hff, 8'd11);
    chk("rep_second", (up_q.size() > 1) ? 8'(up_q[1] - k0) : 8'hff, 8'd43);
    chk("rep_period", (up_q.size() > 2) ? 8'(up_q[2] - up_q[1]) : 8'hff, 8'd8);

    // Both held: silent; releasing down restarts an up hold
    pulse_cnt = 0;
    btn_up = 1'b1;
    btn_down = 1'b1;
    run(200);
    chk("both_pulses", pulse_cnt[7:0], 8'h0);
    up_q.delete();
    k0 = n;
    btn_down = 1'b0;
    run(60);
    chk("rel_other", (up_q.size() > 0) ? 8'(up_q[0] - k0) : 8'hff, 8'd11);
    btn_up = 1'b0;
    run(30);

    // Up held across a mode press does not adjust the new field
    btn_up = 1'b1;
    run(15);
    btn_mode = 1'b1;
    run(20);
    btn_mode = 1'b0;
    up_q.delete();
    run(100);
    chk("held_across_mode", up_q.size(), 8'h0);
    chk("held_state_min", {mode_hour, mode_minute, mode_second}, 8'h5);
    btn_up = 1'b0;
    run(20);
    up_q.delete();
    k0 = n;
    btn_up = 1'b1;
    run(20);
    btn_up = 1'b0;
    run(20);
    chk("repress_pulse", (up_q.size() > 0) ? 8'(up_q[0] - k0) : 8'hff, 8'd11);

    // Idle timeout from SET_HOUR: cleared by the mode release, fires 1024 cycles later
    btn_mode = 1'b1;
    run(20);
    t0 = n;
    btn_mode = 1'b0;
    run(1030);
    chk("idle_still_set", setting, 8'h1);
    run(10);
    chk("idle_timeout", setting, 8'h0);
    chk("idle_mode", {mode_hour, mode_minute, mode_second}, 8'h7);

    // Button activity around cycle 1000 restarts the timeout
    press_mode();
    press_mode();
    btn_mode = 1'b1;
    run(20);
    t0 = n;
    btn_mode = 1'b0;
    run(1000);
    btn_up = 1'b1;
    run(20);
    btn_up = 1'b0;
    run(20);
    chk("idle_restart_set", setting, 8'h1);
    run(1020);
    chk("idle_restart_expired", setting, 8'h0);

    // Random button traffic against the model
    for (int s = 0; s < 60; s++) begin
      v = $urandom;
      btn_mode = (v % 8 == 0);
      btn_up   = v[4];
      btn_down = v[5];
      run($urandom_range(1, 60));
    end
    btn_mode = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
